// File: rtl/complement_pipe.sv
`default_nettype none
// ============================================================================
// Module      : complement_pipe
// Description : Two-stage pipelined two's-complement <-> sign-magnitude
//               converter for CHANNELS words of WORD_LENGHT bits, with
//               per-channel overflow flags, valid/ready backpressure and a
//               saturating overflow event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module complement_pipe #(
    parameter int WORD_LENGHT = 8,
    parameter int CHANNELS    = 2,
    parameter int OVF_CNT_W   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_mode,
    input  logic [CHANNELS*WORD_LENGHT-1:0] in_word,
    input  logic [CHANNELS-1:0]             in_sign,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNELS*WORD_LENGHT-1:0] out_word,
    output logic [CHANNELS-1:0]             out_sign,
    output logic [CHANNELS-1:0]             out_ovf,
    output logic                            out_mode,
    output logic [OVF_CNT_W-1:0]            ovf_count,
    input  logic                            ovf_clear
);

    localparam int                   c_W       = WORD_LENGHT;
    localparam int                   c_DW      = CHANNELS * WORD_LENGHT;
    localparam logic [c_W-1:0]       c_ONE     = c_W'(1);
    localparam logic [c_W-1:0]       c_MIN_NEG = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [OVF_CNT_W-1:0] c_CNT_ONE = OVF_CNT_W'(1);
    localparam logic [OVF_CNT_W-1:0] c_CNT_MAX = {OVF_CNT_W{1'b1}};

    // Stage 1: captured operands and mode
    logic                r_s1_valid;
    logic [c_DW-1:0]     r_s1_word;
    logic [CHANNELS-1:0] r_s1_sign;
    logic                r_s1_mode;

    // Stage 2: converted result
    logic                r_s2_valid;
    logic [c_DW-1:0]     r_s2_word;
    logic [CHANNELS-1:0] r_s2_sign;
    logic [CHANNELS-1:0] r_s2_ovf;
    logic                r_s2_mode;

    logic [OVF_CNT_W-1:0] r_ovf_count;

    // Conversion results computed from stage 1
    logic [c_DW-1:0]     w_conv_word;
    logic [CHANNELS-1:0] w_conv_sign;
    logic [CHANNELS-1:0] w_conv_ovf;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;
    logic w_any_ovf;

    // Handshake: a stage advances when it is empty or its successor advances
    always_comb begin
        w_s2_adv  = !r_s2_valid || out_ready;
        w_s1_adv  = !r_s1_valid || w_s2_adv;
        w_accept  = r_s2_valid && out_ready;
        w_any_ovf = |r_s2_ovf;
    end

    assign in_ready = w_s1_adv;

    // Per-channel converters; channels are fully independent
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic [c_W-1:0] w_x;
        logic [c_W-1:0] w_neg;
        logic [c_W-1:0] w_res;
        logic           w_sgn;
        logic           w_ovf;

        // Negation is shared by both directions; mode selects sign/overflow rules
        always_comb begin
            w_x   = r_s1_word[k*c_W +: c_W];
            w_neg = (~w_x) + c_ONE;
            w_res = w_x;
            w_sgn = 1'b0;
            w_ovf = 1'b0;
            if (!r_s1_mode) begin
                // Most-negative input negates to itself: the unsigned reading
                // of that pattern is the correct magnitude, only the flag marks it
                w_sgn = w_x[c_W-1];
                w_res = w_x[c_W-1] ? w_neg : w_x;
                w_ovf = (w_x == c_MIN_NEG);
            end else begin
                // Negative zero falls out naturally: -0 is 0 with a clear MSB
                w_res = r_s1_sign[k] ? w_neg : w_x;
                w_sgn = w_res[c_W-1];
                w_ovf = r_s1_sign[k] ? (w_x > c_MIN_NEG) : w_x[c_W-1];
            end
        end

        assign w_conv_word[k*c_W +: c_W] = w_res;
        assign w_conv_sign[k]            = w_sgn;
        assign w_conv_ovf[k]             = w_ovf;
    end

    // Stage 1 register: data only loads with a valid input so bubbles keep old data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_s1_sign  <= '0;
            r_s1_mode  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_word <= in_word;
                r_s1_sign <= in_sign;
                r_s1_mode <= in_mode;
            end
        end
    end

    // Stage 2 register: holds the converted result stable while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
            r_s2_sign  <= '0;
            r_s2_ovf   <= '0;
            r_s2_mode  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_word <= w_conv_word;
                r_s2_sign <= w_conv_sign;
                r_s2_ovf  <= w_conv_ovf;
                r_s2_mode <= r_s1_mode;
            end
        end
    end

    // Overflow event counter: clear wins over increment, saturates at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count <= '0;
        end else if (w_accept && w_any_ovf && (r_ovf_count != c_CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + c_CNT_ONE;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_word  = r_s2_word;
    assign out_sign  = r_s2_sign;
    assign out_ovf   = r_s2_ovf;
    assign out_mode  = r_s2_mode;
    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_complement_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_complement_pipe
// Description : Self-checking bench for complement_pipe (W=8, C=2, 2-bit
//               overflow counter) using a scoreboard queue of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complement_pipe;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int CW = 2;

    typedef struct packed {
        logic [C*W-1:0] word;
        logic [C-1:0]   sign;
        logic [C-1:0]   ovf;
        logic           mode;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [C*W-1:0] in_word;
    logic [C-1:0]  in_sign;
    logic          out_valid;
    logic          out_ready;
    logic [C*W-1:0] out_word;
    logic [C-1:0]  out_sign;
    logic [C-1:0]  out_ovf;
    logic          out_mode;
    logic [CW-1:0] ovf_count;
    logic          ovf_clear;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   exp_cnt  = 0;

    complement_pipe #(
        .WORD_LENGHT (W),
        .CHANNELS    (C),
        .OVF_CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_word   (in_word),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_sign  (out_sign),
        .out_ovf   (out_ovf),
        .out_mode  (out_mode),
        .ovf_count (ovf_count),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the numeric value each encoding represents
    function automatic exp_t model(input logic m, input logic [C*W-1:0] w, input logic [C-1:0] s);
        exp_t       e;
        logic [7:0] x;
        int         v;
        e = '0;
        e.mode = m;
        for (int k = 0; k < C; k++) begin
            x = w[k*W +: W];
            if (!m) begin
                v = $signed(x);
                e.sign[k] = (v < 0);
                e.ovf[k]  = (v == -128);
                if (v < 0) v = -v;
                e.word[k*W +: W] = v[7:0];
            end else begin
                v = s[k] ? -int'(x) : int'(x);
                e.ovf[k] = (v > 127) || (v < -128);
                e.word[k*W +: W] = v[7:0];
                e.sign[k] = v[7];
            end
        end
        return e;
    endfunction

    // Drive one transaction, record its expected result at the accepting edge
    task automatic send(input logic m, input logic [C*W-1:0] w, input logic [C-1:0] s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_word  = w;
        in_sign  = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) q.push_back(model(m, w, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Scoreboard and overflow-counter model, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            check("ovf_count", {30'd0, ovf_count}, exp_cnt);
            if (out_valid && out_ready) begin
                check("sb_not_empty", {31'd0, (q.size() > 0)}, 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("sb_word", {16'd0, out_word}, {16'd0, e.word});
                    check("sb_sign", {30'd0, out_sign}, {30'd0, e.sign});
                    check("sb_ovf",  {30'd0, out_ovf},  {30'd0, e.ovf});
                    check("sb_mode", {31'd0, out_mode}, {31'd0, e.mode});
                end
            end
            if (ovf_clear) exp_cnt = 0;
            else if (out_valid && out_ready && (|out_ovf) && exp_cnt != 3) exp_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [C*W-1:0] held;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_word   = '0;
        in_sign   = '0;
        out_ready = 1'b1;
        ovf_clear = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word",  {16'd0, out_word},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_ovf_count", {30'd0, ovf_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Mode 0 basic conversion with explicit latency check
        send(1'b0, 16'h05F6, 2'b00);
        check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
        check("m0_word", {16'd0, out_word}, 32'h050A);
        check("m0_sign", {30'd0, out_sign}, 32'd1);
        check("m0_ovf",  {30'd0, out_ovf},  32'd0);
        drain();

        // Mode 0 most-negative value: overflow and counter 0 -> 1
        check("cnt_before", {30'd0, ovf_count}, 32'd0);
        send(1'b0, 16'h0180, 2'b00);
        @(posedge clk);
        #1;
        check("m0_min_word", {16'd0, out_word}, 32'h0180);
        check("m0_min_sign", {30'd0, out_sign}, 32'd1);
        check("m0_min_ovf",  {30'd0, out_ovf},  32'd1);
        drain();
        check("cnt_after_one", {30'd0, ovf_count}, 32'd1);

        // Mode 1 pairs, including negative zero and overflow edges
        send(1'b1, 16'h000A, 2'b11);
        send(1'b1, 16'h8080, 2'b01);
        send(1'b1, 16'h0581, 2'b01);
        drain();
        check("cnt_after_m1", {30'd0, ovf_count}, 32'd3);

        // Plain clear
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        check("cnt_cleared", {30'd0, ovf_count}, 32'd0);

        // Backpressure: two captured, input stalls, first result held stable
        out_ready = 1'b0;
        send(1'b0, 16'h7F81, 2'b00);
        send(1'b1, 16'h0203, 2'b10);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        e = model(1'b0, 16'h7F81, 2'b00);
        held = e.word;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_word",  {16'd0, out_word},  {16'd0, held});
            check("bp_hold_ready", {31'd0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, 16'hFF00, 2'b00);
        send(1'b1, 16'h7F7F, 2'b11);
        drain();

        // Asynchronous reset with two transactions in flight
        send(1'b0, 16'h1234, 2'b00);
        send(1'b1, 16'h5678, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_out_word",  {16'd0, out_word},  32'd0);
        check("ar_out_sign",  {30'd0, out_sign},  32'd0);
        check("ar_out_ovf",   {30'd0, out_ovf},   32'd0);
        check("ar_out_mode",  {31'd0, out_mode},  32'd0);
        check("ar_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(1'b0, 16'h80FF, 2'b00);
        check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_lat2", {31'd0, out_valid}, 32'd1);
        e = model(1'b0, 16'h80FF, 2'b00);
        check("post_rst_word", {16'd0, out_word}, {16'd0, e.word});
        drain();

        // Saturation: from 1, five more overflowing transactions pin at 3
        for (int i = 0; i < 5; i++) send(1'b0, 16'h0080, 2'b00);
        drain();
        check("cnt_saturated", {30'd0, ovf_count}, 32'd3);

        // Clear coinciding with an overflowing acceptance yields 0
        out_ready = 1'b0;
        send(1'b0, 16'h8000, 2'b00);
        wait_valid();
        out_ready = 1'b1;
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        check("cnt_clear_priority", {30'd0, ovf_count}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/complement_pipe.md
# complement_pipe

Parametrised, pipelined two's-complement / sign-magnitude converter. It handles `CHANNELS` words of `WORD_LENGHT` bits per transaction and carries a per-transaction conversion direction. Results carry overflow flags, and a saturating counter tallies overflow events. It sits between the operand registers and the unsigned-magnitude datapaths (multiplier/divider), converting operands going in and results coming out, with valid/ready backpressure.

## Interface
- `WORD_LENGHT`, default 8: bits per channel word (≥ 2).
- `CHANNELS`, default 2: words per transaction (≥ 1).
- `OVF_CNT_W`, default 8: width of overflow event counter.
- `clk`  in  1: clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input transaction valid.
- `in_ready`  out  1: block accepts the transaction this cycle.
- `in_mode`  in  1: 0 = two's complement → sign-magnitude; 1 = sign-magnitude → two's complement.
- `in_word`  in  CHANNELS*WORD_LENGHT: packed words; channel k at bits [k*W +: W].
- `in_sign`  in  CHANNELS: sign bit per channel. Used in mode 1 only.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_word`  out  CHANNELS*WORD_LENGHT: converted words, same packing.
- `out_sign`  out  CHANNELS: sign per channel.
- `out_ovf`  out  CHANNELS: per-channel overflow flag.
- `out_mode`  out  1: mode the result was produced with.
- `ovf_count`  out  OVF_CNT_W: saturating count of transactions with any `out_ovf` set.
- `ovf_clear`  in  1: synchronous clear of `ovf_count`.

## Operation
- Mode 0, per channel, with x = in_word channel:
  - `out_sign` = x[W-1].
  - `out_word` = (~x)+1 if the sign is set, else x, truncated to W bits, treated as unsigned magnitude.
  - `out_ovf` = 1 only for x = 100…0: the magnitude 2^(W-1) does not fit W-1 bits. `out_word` = 100…0 (unsigned 2^(W-1)).
- Mode 1, per channel, with m = in_word, s = in_sign:
  - `out_word` = s ? (~m)+1 : m, W bits.
  - `out_sign` = MSB of `out_word`.
  - `out_ovf` = 1 when s=0 and m ≥ 2^(W-1), or s=1 and m > 2^(W-1). The wrapped value is still output.
  - s=1, m=0 (negative zero): `out_word` = 0, `out_sign` = 0, `out_ovf` = 0.
- Channels are independent and share one handshake.
- Overflow counter:
  - Increments by 1 when a result is accepted (`out_valid` && `out_ready`) with any `out_ovf` bit set.
  - Saturates at all-ones.
  - `ovf_clear` has priority over a same-cycle increment: the result is 0.

## Timing
- Two-register pipeline: S1 holds the captured input and mode; S2 holds the converted result. Each stage has a valid bit.
- Latency: 2 cycles from accepted input to `out_valid` when unstalled. Throughput is 1 transaction/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - `in_ready` = s1_adv (combinational from `out_ready` and state).
  - S2 loads from S1 when s2_adv. S1 loads the input when s1_adv.
  - A stage whose valid bit clears keeps its data; that data is don't-care.
- While `out_valid`=1 && `out_ready`=0, `out_*` stays stable until accepted.
- `in_valid`=0 with s1_adv inserts a bubble (S1 valid ← 0). No transaction is lost or duplicated.
- Reset (asynchronous, `reset`=0), at any time including mid-stream:
  - Both valid bits ← 0. All data registers ← 0.
  - `out_valid`=0, `out_word`=0, `out_sign`=0, `out_ovf`=0, `out_mode`=0, `ovf_count`=0.
  - `in_ready` reads 1 during and after reset.
  - In-flight transactions are discarded.
- The S2 register, not the S1 input, provides `out_*`. No combinational path runs from `in_*` to `out_*`.

## Test plan
- W=8, C=2, mode 0, words {0xF6, 0x05}, `out_ready`=1:
  - 2 cycles later, `out_word` {0x0A, 0x05}, sign {1,0}, ovf {0,0}.
- Mode 0, word 0x80:
  - `out_word` 0x80, sign 1, ovf 1.
  - `ovf_count` goes 0→1 on acceptance.
- Mode 1, word/sign pairs:
  - {0x0A,1} → 0xF6, sign 1.
  - {0x00,1} → 0x00, sign 0, ovf 0.
  - {0x80,1} → 0x80, ovf 0.
  - {0x80,0} → ovf 1.
  - {0x81,1} → ovf 1.
- Backpressure, 4 back-to-back inputs:
  - Hold `out_ready`=0 for 3 cycles.
  - `in_ready` drops after 2 inputs are captured.
  - The first result is held stable.
  - After release, all 4 results emerge in order with no loss or duplication.
- Assert `reset`=0 while 2 transactions are in flight:
  - `out_valid` drops immediately and outputs read 0.
  - After release, a new input yields its result in 2 cycles.
- Counter, with `OVF_CNT_W`=2:
  - 5 overflowing transactions → `ovf_count` saturates at 3.
  - `ovf_clear` together with an overflowing acceptance → `ovf_count`=0.
